// File: rtl/seq_serializer.sv
// rtl/seq_serializer.sv - parallel-to-serial front end feeding the sequence detector bit input
module seq_serializer #(
    parameter int WIDTH     = 8,
    parameter int GAP       = 0,
    parameter int IDLE_BIT  = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST     = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   PRELAST  = CW'(WIDTH - 2);
    localparam logic [7:0]      GAP_LEN  = 8'(GAP);
    localparam logic            IDLE_LVL = 1'(IDLE_BIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic [7:0]       gap_cnt;

    logic             last_bit;
    logic             take;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] din_rest;
    logic [WIDTH-1:0] shreg_rest;

    assign last_bit  = (state == S_SHIFT) && (bit_cnt == LAST);
    // Back-to-back reload is only offered on the last bit when no gap follows.
    assign din_ready = !rst && ((state == S_IDLE) || (last_bit && (GAP == 0)));
    assign take      = din_valid && din_ready;
    assign busy      = (state != S_IDLE);

    assign first_bit  = (MSB_FIRST != 0) ? din[WIDTH-1]   : din[0];
    assign next_bit   = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
    assign din_rest   = (MSB_FIRST != 0) ? (din << 1)     : (din >> 1);
    assign shreg_rest = (MSB_FIRST != 0) ? (shreg << 1)   : (shreg >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            x          <= IDLE_LVL;
            x_valid    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (take) begin
                // First bit goes straight to x; the rest wait in shreg.
                state   <= S_SHIFT;
                x       <= first_bit;
                x_valid <= 1'b1;
                shreg   <= din_rest;
                bit_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        x       <= IDLE_LVL;
                        x_valid <= 1'b0;
                    end
                    S_SHIFT: begin
                        if (bit_cnt != LAST) begin
                            x          <= next_bit;
                            shreg      <= shreg_rest;
                            bit_cnt    <= bit_cnt + 1'b1;
                            frame_done <= (bit_cnt == PRELAST);
                        end else begin
                            x       <= IDLE_LVL;
                            x_valid <= 1'b0;
                            bit_cnt <= '0;
                            if (GAP == 0) begin
                                state <= S_IDLE;
                            end else begin
                                state   <= S_GAP;
                                gap_cnt <= GAP_LEN;
                            end
                        end
                    end
                    S_GAP: begin
                        x       <= IDLE_LVL;
                        x_valid <= 1'b0;
                        if (gap_cnt <= 8'd1) begin
                            state   <= S_IDLE;
                            gap_cnt <= '0;
                        end else begin
                            gap_cnt <= gap_cnt - 8'd1;
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        x       <= IDLE_LVL;
                        x_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// tb/tb_seq_serializer.sv - directed bench for seq_serializer in three parameterisations
module tb_seq_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // d0: GAP=0 MSB first; d2: GAP=2 MSB first; dl: GAP=0 LSB first
    logic       rst0 = 1'b1, v0 = 1'b0, rdy0, x0, xv0, busy0, fd0;
    logic [7:0] din0 = 8'h00;
    logic       rst2 = 1'b1, v2 = 1'b0, rdy2, x2, xv2, busy2, fd2;
    logic [7:0] din2 = 8'h00;
    logic       rstl = 1'b1, vl = 1'b0, rdyl, xl, xvl, busyl, fdl;
    logic [7:0] dinl = 8'h00;

    seq_serializer #(.WIDTH(8), .GAP(0), .IDLE_BIT(1), .MSB_FIRST(1)) d0 (
        .clk(clk), .rst(rst0), .din(din0), .din_valid(v0), .din_ready(rdy0),
        .x(x0), .x_valid(xv0), .busy(busy0), .frame_done(fd0));

    seq_serializer #(.WIDTH(8), .GAP(2), .IDLE_BIT(1), .MSB_FIRST(1)) d2 (
        .clk(clk), .rst(rst2), .din(din2), .din_valid(v2), .din_ready(rdy2),
        .x(x2), .x_valid(xv2), .busy(busy2), .frame_done(fd2));

    seq_serializer #(.WIDTH(8), .GAP(0), .IDLE_BIT(1), .MSB_FIRST(0)) dl (
        .clk(clk), .rst(rstl), .din(dinl), .din_valid(vl), .din_ready(rdyl),
        .x(xl), .x_valid(xvl), .busy(busyl), .frame_done(fdl));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick();
        total++;
        if ({x0, xv0, fd0, busy0, rdy0} !== 5'b10000) $display("FAIL reset_d0 got %b want 10000", {x0, xv0, fd0, busy0, rdy0});
        else passed++;
        total++;
        if ({x2, xv2, fd2, busy2, rdy2, xl, xvl, rdyl} !== 8'b10000100) $display("FAIL reset_d2_dl got %b want 10000100", {x2, xv2, fd2, busy2, rdy2, xl, xvl, rdyl});
        else passed++;
        rst0 = 1'b0; rst2 = 1'b0; rstl = 1'b0;
        #1;
        total++;
        if ({rdy0, rdy2, rdyl} !== 3'b111) $display("FAIL ready_after_reset got %b want 111", {rdy0, rdy2, rdyl});
        else passed++;
    endtask

    task automatic test_single();
        logic [7:0] w = 8'h66;
        int errs = 0;
        din0 = w; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (x0 !== w[8-i] || xv0 !== 1'b1 || fd0 !== (i == 8) || busy0 !== 1'b1) begin
                $display("FAIL single_bit%0d got x=%b xv=%b fd=%b busy=%b want x=%b xv=1 fd=%b busy=1", i, x0, xv0, fd0, busy0, w[8-i], (i == 8));
                errs++;
            end
            tick();
        end
        total++;
        if (errs != 0) $display("FAIL single_frame got %0d bad cycles want 0", errs);
        else passed++;
        total++;
        if ({x0, xv0, rdy0, fd0, busy0} !== 5'b10100) $display("FAIL single_after got %b want 10100", {x0, xv0, rdy0, fd0, busy0});
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] w = 16'h66A5;
        int errs = 0;
        int rdy_errs = 0;
        din0 = 8'h66; v0 = 1'b1;
        tick();
        din0 = 8'hA5;
        for (int i = 1; i <= 16; i++) begin
            if (x0 !== w[16-i] || xv0 !== 1'b1 || fd0 !== (i == 8 || i == 16)) begin
                $display("FAIL b2b_bit%0d got x=%b xv=%b fd=%b want x=%b xv=1 fd=%b", i, x0, xv0, fd0, w[16-i], (i == 8 || i == 16));
                errs++;
            end
            if (i <= 8 && rdy0 !== (i == 8)) begin
                $display("FAIL b2b_ready%0d got %b want %b", i, rdy0, (i == 8));
                rdy_errs++;
            end
            tick();
            if (i == 8) v0 = 1'b0;
        end
        total++;
        if (errs != 0) $display("FAIL b2b_stream got %0d bad cycles want 0", errs);
        else passed++;
        total++;
        if (rdy_errs != 0) $display("FAIL b2b_hold_ready got %0d bad cycles want 0", rdy_errs);
        else passed++;
        total++;
        if ({xv0, x0, busy0} !== 3'b010) $display("FAIL b2b_end got %b want 010", {xv0, x0, busy0});
        else passed++;
    endtask

    task automatic test_gap();
        logic [7:0] w = 8'h66;
        int errs = 0;
        din2 = w; v2 = 1'b1;
        tick();
        din2 = 8'hA5;
        for (int i = 1; i <= 8; i++) begin
            if (x2 !== w[8-i] || xv2 !== 1'b1 || rdy2 !== 1'b0 || fd2 !== (i == 8)) begin
                $display("FAIL gap_bit%0d got x=%b xv=%b rdy=%b fd=%b want x=%b xv=1 rdy=0 fd=%b", i, x2, xv2, rdy2, fd2, w[8-i], (i == 8));
                errs++;
            end
            tick();
        end
        total++;
        if (errs != 0) $display("FAIL gap_frame got %0d bad cycles want 0", errs);
        else passed++;
        for (int i = 9; i <= 10; i++) begin
            total++;
            if ({x2, xv2, rdy2, busy2} !== 4'b1001) $display("FAIL gap_cycle%0d got %b want 1001", i, {x2, xv2, rdy2, busy2});
            else passed++;
            tick();
        end
        total++;
        if ({x2, xv2, rdy2, busy2} !== 4'b1010) $display("FAIL gap_idle got %b want 1010", {x2, xv2, rdy2, busy2});
        else passed++;
        tick();
        v2 = 1'b0;
        total++;
        if ({x2, xv2} !== 2'b11) $display("FAIL gap_second_first_bit got %b want 11", {x2, xv2});
        else passed++;
        for (int i = 0; i < 8; i++) tick();
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_lsb_first();
        logic [7:0] exp = 8'b10000000;
        logic [7:0] got;
        dinl = 8'h01; vl = 1'b1;
        tick();
        vl = 1'b0;
        for (int i = 0; i < 8; i++) begin
            got[7-i] = xl;
            if (i == 7) begin
                total++;
                if (fdl !== 1'b1) $display("FAIL lsb_frame_done got %b want 1", fdl);
                else passed++;
            end
            tick();
        end
        total++;
        if (got !== exp) $display("FAIL lsb_bits got %b want %b", got, exp);
        else passed++;
    endtask

    task automatic test_mid_reset();
        logic [7:0] w = 8'hA5;
        logic [7:0] got;
        int fd_errs = 0;
        din0 = 8'h66; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        tick(); tick();
        total++;
        if ({x0, xv0} !== 2'b11) $display("FAIL rst_pre got %b want 11", {x0, xv0});
        else passed++;
        rst0 = 1'b1;
        tick();
        total++;
        if ({x0, xv0, fd0, rdy0, busy0} !== 5'b10000) $display("FAIL rst_mid got %b want 10000", {x0, xv0, fd0, rdy0, busy0});
        else passed++;
        rst0 = 1'b0;
        #1;
        total++;
        if (rdy0 !== 1'b1) $display("FAIL rst_ready got %b want 1", rdy0);
        else passed++;
        din0 = w; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            got[8-i] = x0;
            if (fd0 !== (i == 8)) fd_errs++;
            tick();
        end
        total++;
        if (got !== w) $display("FAIL rst_new_word got %h want %h", got, w);
        else passed++;
        total++;
        if (fd_errs != 0) $display("FAIL rst_frame_done got %0d bad cycles want 0", fd_errs);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_lsb_first();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
